instr_sequencer: RTL

//  Upstream feeder for the processor core. Holds a small loadable program memory of
//  3-byte instructions {opcode, operand1, operand2} and issues them one at a time on

---
 rtl/instr_sequencer.sv | 97 +++++++++
 1 files changed

// File: rtl/instr_sequencer.sv
// Program sequencer feeding the processor core: issues stored 3-byte instructions,
// waits out the core latency, captures result/flags and steps the PC until HALT or end of memory.
module instr_sequencer #(
    parameter int         PROG_DEPTH     = 16,
    parameter int         ADDR_W         = 4,
    parameter int         RESULT_LATENCY = 2,
    parameter logic [7:0] HALT_OPCODE    = 8'hFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [23:0]       load_data,
    input  logic              start,
    output logic [7:0]        opcode,
    output logic [7:0]        operand1,
    output logic [7:0]        operand2,
    input  logic [7:0]        core_result,
    input  logic [7:0]        core_flags,
    output logic [7:0]        last_result,
    output logic [7:0]        last_flags,
    output logic              result_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              done
);
    localparam int CNT_W = $clog2(RESULT_LATENCY) + 1;

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, CAPTURE, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt;
    logic [23:0]      mem [PROG_DEPTH];
    logic [23:0]      mem_word;
    logic             is_halt;
    logic             last_addr;

    assign mem_word  = mem[pc];
    assign is_halt   = (mem_word[23:16] == HALT_OPCODE);
    assign last_addr = (pc == ADDR_W'(PROG_DEPTH - 1));
    assign busy      = (state_q == FETCH) || (state_q == WAIT) || (state_q == CAPTURE);

    // Program memory survives reset; writes are locked out while a program runs.
    always_ff @(posedge clk) begin
        if (load_en && (state_q == IDLE || state_q == DONE))
            mem[load_addr] <= load_data;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = FETCH;
            FETCH:   state_d = is_halt ? DONE : WAIT;
            WAIT:    if (cnt == CNT_W'(RESULT_LATENCY - 1)) state_d = CAPTURE;
            CAPTURE: state_d = last_addr ? DONE : FETCH;
            DONE:    if (start) state_d = FETCH;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pc           <= '0;
            cnt          <= '0;
            opcode       <= '0;
            operand1     <= '0;
            operand2     <= '0;
            last_result  <= '0;
            last_flags   <= '0;
            result_valid <= 1'b0;
            done         <= 1'b0;
        end else begin
            state_q      <= state_d;
            result_valid <= 1'b0;
            // done follows the state with one cycle of lag
            done         <= (state_q == DONE);
            case (state_q)
                IDLE, DONE: if (start) pc <= '0;
                FETCH: begin
                    cnt <= '0;
                    if (is_halt) {opcode, operand1, operand2} <= '0;
                    else         {opcode, operand1, operand2} <= mem_word;
                end
                WAIT: cnt <= cnt + CNT_W'(1);
                CAPTURE: begin
                    last_result  <= core_result;
                    last_flags   <= core_flags;
                    result_valid <= 1'b1;
                    if (last_addr) {opcode, operand1, operand2} <= '0;
                    else           pc <= pc + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end
endmodule
